// File: rtl/spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine
//
// SPI mode 0 (CPOL=0, CPHA=0) full-duplex transfer engine. It sits right after
// the SPI clock generator: it enables the generator through clock_en_o and
// reacts to the generator's "SCK about to rise / fall" strobes. One start
// request moves 1..DATA_W bits out on MOSI and in from MISO, framed by CS_n.
//
// Optional feature (compile-time macro SPI_LSB_FIRST_EN):
//   When defined, an extra input lsb_first_i is latched with start. When it is
//   1, the word is transmitted from tx[0] upward, and received bits fill rx
//   from bit 0 upward. When the macro is undefined, only MSB-first transfers
//   are built and the port is absent.
//
// Parameters:
//   DATA_W  maximum transfer length / data width in bits
//   CNT_W   width of the length and bit counters (2**CNT_W > DATA_W)
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   start_i      transfer request, only honoured while idle
//   tx_data_i    transmit word, right-aligned
//   tx_len_i     bits to transfer; 0 or > DATA_W selects DATA_W
//   busy_o       high from the cycle after an accepted start through done_o
//   done_o       one-cycle completion pulse
//   rx_data_o    received word, right-aligned, unused upper bits zero
//   clock_en_o   enable to the SPI clock generator
//   rise_edge_i  strobe from the clock generator: SCK about to rise
//   fall_edge_i  strobe from the clock generator: SCK about to fall
//   spi_cs_n_o   chip select, active-low
//   spi_mosi_o   serial data out
//   spi_miso_i   serial data in
//   lsb_first_i  (SPI_LSB_FIRST_EN only) 1 = LSB-first transfer
// -----------------------------------------------------------------------------
module spi_shift_engine #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic [CNT_W-1:0]  tx_len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              clock_en_o,
  input  logic              rise_edge_i,
  input  logic              fall_edge_i,
  output logic              spi_cs_n_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i
`ifdef SPI_LSB_FIRST_EN
  ,
  input  logic              lsb_first_i
`endif
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              mosi_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              busy_q;
  logic              done_q;
  logic              clk_en_q;
  logic              cs_n_q;

  logic              lsb_in;
  logic              lsb_mode;

  logic [CNT_W-1:0]  eff_len;
  logic              accept;
  logic              rise_ok;
  logic              fall_ok;
  logic              last_fall;
  logic [IDX_W-1:0]  first_idx;
  logic [IDX_W-1:0]  next_idx;
  logic [IDX_W-1:0]  rx_idx;
  logic              first_bit;
  logic              next_bit;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] rx_mask;

  // Bit order selection. Without the LSB-first build the order is fixed.
`ifdef SPI_LSB_FIRST_EN
  logic lsb_q;

  assign lsb_in   = lsb_first_i;
  assign lsb_mode = lsb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lsb_q <= 1'b0;
    end else if (accept) begin
      lsb_q <= lsb_first_i;
    end
  end
`else
  assign lsb_in   = 1'b0;
  assign lsb_mode = 1'b0;
`endif

  // Effective length: 0 and anything above DATA_W both mean a full word.
  always_comb begin
    eff_len = tx_len_i;
    if ((tx_len_i == '0) || (tx_len_i > FULL_LEN)) begin
      eff_len = FULL_LEN;
    end
  end

  // Qualified events. A rise and a fall in the same cycle is illegal upstream;
  // the rise wins and the fall is dropped. Rises beyond the length are ignored
  // so the bit counter can never pass L.
  always_comb begin
    accept    = (state_q == IDLE) && start_i;
    rise_ok   = (state_q == XFER) && rise_edge_i && (bit_cnt_q < len_q);
    fall_ok   = (state_q == XFER) && fall_edge_i && !rise_edge_i;
    last_fall = fall_ok && (bit_cnt_q == len_q);
  end

  // Bit selection. After k rising edges the next transmit bit is tx[L-1-k]
  // (MSB-first) or tx[k] (LSB-first); before the first rise this is simply the
  // first bit again, so an early fall strobe is harmless.
  always_comb begin
    first_idx = lsb_in ? '0 : IDX_W'(eff_len - CNT_W'(1));
    next_idx  = lsb_mode ? IDX_W'(bit_cnt_q)
                         : IDX_W'(len_q - bit_cnt_q - CNT_W'(1));
    rx_idx    = IDX_W'(bit_cnt_q);
    first_bit = tx_data_i[first_idx];
    next_bit  = tx_q[next_idx];
    rx_next   = {rx_q[DATA_W-2:0], spi_miso_i};
    if (lsb_mode) begin
      rx_next         = rx_q;
      rx_next[rx_idx] = spi_miso_i;
    end
    rx_mask = ~({DATA_W{1'b1}} << len_q);
  end

  // Next-state logic. SETUP and HOLD are single-cycle guard states around the
  // SCK burst so CS_n has margin on both sides of the data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SETUP;
      SETUP:   state_d = XFER;
      XFER:    if (last_fall) state_d = HOLD;
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered control outputs. Outputs are decoded from
  // the next state so they are glitch-free and line up with the state itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clk_en_q <= 1'b0;
      cs_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
      clk_en_q <= (state_d == XFER);
      cs_n_q   <= !(state_d inside {SETUP, XFER, HOLD});
    end
  end

  // Transfer context and shift register. Everything is captured at start so
  // later changes on the request inputs cannot disturb a running transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_q      <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
    end else if (accept) begin
      tx_q      <= tx_data_i;
      len_q     <= eff_len;
      bit_cnt_q <= '0;
      rx_q      <= '0;
    end else if (rise_ok) begin
      rx_q      <= rx_next;
      bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end
  end

  // MOSI: first bit is presented in SETUP, later bits change on falling SCK
  // (mode 0 slaves sample on the rising edge), and the line parks low again
  // once the transfer is reported done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mosi_q <= 1'b0;
    end else if (accept) begin
      mosi_q <= first_bit;
    end else if (state_d == DONE) begin
      mosi_q <= 1'b0;
    end else if (fall_ok && (bit_cnt_q < len_q)) begin
      mosi_q <= next_bit;
    end
  end

  // Received word is published only when done_o fires; the mask keeps bits
  // above L-1 at zero regardless of bit order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_q <= '0;
    end else if (state_d == DONE) begin
      rx_data_q <= rx_q & rx_mask;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rx_data_o  = rx_data_q;
  assign clock_en_o = clk_en_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_shift_engine
//
// Self-checking bench for spi_shift_engine. A divide-by-4 SCK generator model
// answers clock_en_o with rise/fall strobes; MISO is either looped back from
// MOSI or fed from a pattern word. Expected results come from a word-level
// model: L = clamp(len), mask = 2**L-1, MOSI word = tx & mask,
// RX = (loopback ? tx : pattern) & mask, exactly L rise and L fall edges.
// Build with +define+SPI_LSB_FIRST_EN to also cover LSB-first transfers.
// -----------------------------------------------------------------------------
module tb_spi_shift_engine;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int HIST   = 8192;

  logic              clk;
  logic              rst;
  logic              start;
  logic [31:0]       tx_data;
  logic [5:0]        tx_len;
  logic              busy;
  logic              done;
  logic [31:0]       rx_data;
  logic              clock_en;
  logic              rise_edge;
  logic              fall_edge;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              lsb_first;

  int n_cmp;
  int n_fail;

  // Generator / monitor state
  int          div_cnt;
  logic        sck;
  logic        prev_clock_en;
  logic        prev_mosi;
  logic        gen_force;
  logic        force_rise;
  logic        force_fall;
  logic        loop_mode;
  logic [31:0] pat_word;
  int          cur_len;
  logic        cur_lsb;
  int          rise_base;
  int          rise_total;
  int          fall_total;
  int          done_total;
  int          cs_bad;
  int          busy_bad;
  int          both_bad;
  logic        track_busy;
  logic        mosi_hist [HIST];
  logic [31:0] exp_prev_rx;

  typedef struct {
    logic [31:0] tx;
    int          len;
    logic        loop;
    logic [31:0] pat;
    logic [31:0] exp_rx;
    logic [31:0] exp_mosi;
    int          exp_edges;
  } vec_t;

  vec_t vecs [7];

  spi_shift_engine #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .tx_data_i   (tx_data),
    .tx_len_i    (tx_len),
    .busy_o      (busy),
    .done_o      (done),
    .rx_data_o   (rx_data),
    .clock_en_o  (clock_en),
    .rise_edge_i (rise_edge),
    .fall_edge_i (fall_edge),
    .spi_cs_n_o  (cs_n),
    .spi_mosi_o  (mosi),
    .spi_miso_i  (miso)
`ifdef SPI_LSB_FIRST_EN
    ,
    .lsb_first_i (lsb_first)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor then generator, once per cycle on the falling edge. The monitor
  // looks at what the DUT saw on the previous rising edge (strobes still held,
  // outputs saved from the last falling edge); the generator then drives the
  // strobes and MISO for the next rising edge.
  always @(negedge clk) begin
    int k;
    if (prev_clock_en && rise_edge && fall_edge) both_bad++;
    if (prev_clock_en && rise_edge) begin
      mosi_hist[rise_total % HIST] = prev_mosi;
      rise_total++;
    end
    if (prev_clock_en && fall_edge && !rise_edge) fall_total++;
    if (done) done_total++;
    if (clock_en && cs_n) cs_bad++;
    if (track_busy && !busy) busy_bad++;

    rise_edge = 1'b0;
    fall_edge = 1'b0;
    if (gen_force) begin
      rise_edge = force_rise;
      fall_edge = force_fall;
      div_cnt   = 0;
      sck       = 1'b0;
    end else if (!clock_en || rst) begin
      div_cnt = 0;
      sck     = 1'b0;
    end else begin
      div_cnt++;
      if (div_cnt == 2) begin
        div_cnt = 0;
        if (!sck) rise_edge = 1'b1;
        else      fall_edge = 1'b1;
        sck = ~sck;
      end
    end

    k = rise_total - rise_base;
    if (loop_mode)                  miso = mosi;
    else if (k >= 0 && k < cur_len) miso = cur_lsb ? pat_word[k] : pat_word[cur_len-1-k];
    else                            miso = 1'b0;

    prev_clock_en = clock_en;
    prev_mosi     = mosi;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic int modelLen(input int len);
    return (len == 0 || len > DATA_W) ? DATA_W : len;
  endfunction

  function automatic logic [31:0] modelMask(input int l);
    return (l >= 32) ? 32'hFFFF_FFFF : ((32'h1 << l) - 32'h1);
  endfunction

  // One complete transfer with optional disturbance at the 3rd rising edge:
  // inject 1 = extra start pulse, inject 2 = synchronous reset.
  task automatic applyStimulus(input string name, input logic [31:0] tx, input int len,
                               input logic loop, input logic [31:0] pat, input logic lsb,
                               input logic [31:0] exp_rx, input logic [31:0] exp_mosi,
                               input int exp_edges, input int inject);
    int          done_base;
    int          fall_base;
    int          cs_base;
    int          busy_base;
    int          inj_state;
    logic        got;
    logic        first;
    logic [31:0] word;

    loop_mode = loop;
    pat_word  = pat;
    cur_len   = exp_edges;
    cur_lsb   = lsb;
    rise_base = rise_total;
    fall_base = fall_total;
    done_base = done_total;
    cs_base   = cs_bad;
    busy_base = busy_bad;
    inj_state = 0;
    got       = 1'b0;
    first     = lsb ? exp_mosi[0] : exp_mosi[exp_edges-1];

    tx_data   = tx;
    tx_len    = 6'(len);
    lsb_first = lsb;
    start     = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({name, "_setup_busy"}, 32'(busy), 32'd1);
    checkOutput({name, "_setup_cs_n"}, 32'(cs_n), 32'd0);
    checkOutput({name, "_setup_clk_en"}, 32'(clock_en), 32'd0);
    checkOutput({name, "_setup_mosi"}, 32'(mosi), 32'(first));
    checkOutput({name, "_rx_hold"}, rx_data, exp_prev_rx);
    track_busy = 1'b1;

    for (int i = 0; i < 400; i++) begin
      tick();
      if (inj_state == 1) begin
        start     = 1'b0;
        inj_state = 2;
      end
      if (inject != 0 && inj_state == 0 && (rise_total - rise_base) >= 3) begin
        if (inject == 1) begin
          start     = 1'b1;
          tx_data   = 32'hFFFF_FFFF;
          tx_len    = 6'd1;
          inj_state = 1;
        end else begin
          track_busy = 1'b0;
          rst = 1'b1;
          tick();
          checkOutput({name, "_rst_cs_n"}, 32'(cs_n), 32'd1);
          checkOutput({name, "_rst_clk_en"}, 32'(clock_en), 32'd0);
          checkOutput({name, "_rst_busy"}, 32'(busy), 32'd0);
          checkOutput({name, "_rst_rx"}, rx_data, 32'd0);
          checkOutput({name, "_rst_done"}, 32'(done), 32'd0);
          checkOutput({name, "_rst_mosi"}, 32'(mosi), 32'd0);
          rst = 1'b0;
          for (int j = 0; j < 20; j++) tick();
          checkOutput({name, "_rst_no_done"}, 32'(done_total - done_base), 32'd0);
          checkOutput({name, "_rst_idle_busy"}, 32'(busy), 32'd0);
          exp_prev_rx = 32'd0;
          return;
        end
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start      = 1'b0;
    track_busy = 1'b0;

    if (!got) begin
      checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_prev_rx = 32'd0;
      return;
    end

    checkOutput({name, "_busy_at_done"}, 32'(busy), 32'd1);
    checkOutput({name, "_cs_n_at_done"}, 32'(cs_n), 32'd1);
    checkOutput({name, "_rx"}, rx_data, exp_rx);
    tick();
    checkOutput({name, "_done_width"}, 32'(done), 32'd0);
    checkOutput({name, "_busy_after"}, 32'(busy), 32'd0);
    checkOutput({name, "_mosi_park"}, 32'(mosi), 32'd0);
    tick();
    tick();
    word = 32'd0;
    for (int b = 0; b < exp_edges; b++) begin
      if (lsb) word[b]               = mosi_hist[(rise_base + b) % HIST];
      else     word[exp_edges-1-b]   = mosi_hist[(rise_base + b) % HIST];
    end
    checkOutput({name, "_done_count"}, 32'(done_total - done_base), 32'd1);
    checkOutput({name, "_rise_edges"}, 32'(rise_total - rise_base), 32'(exp_edges));
    checkOutput({name, "_fall_edges"}, 32'(fall_total - fall_base), 32'(exp_edges));
    checkOutput({name, "_mosi_word"}, word, exp_mosi);
    checkOutput({name, "_cs_during_sck"}, 32'(cs_bad - cs_base), 32'd0);
    checkOutput({name, "_busy_gap"}, 32'(busy_bad - busy_base), 32'd0);
    checkOutput({name, "_rx_stable"}, rx_data, exp_rx);
    exp_prev_rx = exp_rx;
  endtask

  initial begin
    logic [31:0] rtx;
    logic [31:0] rpat;
    logic        rloop;
    logic        rlsb;
    int          rlen;
    int          l;

    n_cmp = 0;  n_fail = 0;
    div_cnt = 0;  sck = 1'b0;
    prev_clock_en = 1'b0;  prev_mosi = 1'b0;
    gen_force = 1'b0;  force_rise = 1'b0;  force_fall = 1'b0;
    loop_mode = 1'b1;  pat_word = 32'd0;  cur_len = 0;  cur_lsb = 1'b0;
    rise_base = 0;  rise_total = 0;  fall_total = 0;  done_total = 0;
    cs_bad = 0;  busy_bad = 0;  both_bad = 0;  track_busy = 1'b0;
    exp_prev_rx = 32'd0;
    rise_edge = 1'b0;  fall_edge = 1'b0;  miso = 1'b0;
    rst = 1'b1;  start = 1'b0;  tx_data = 32'd0;  tx_len = 6'd0;  lsb_first = 1'b0;

    //                 tx            len loop pattern        exp_rx         exp_mosi      edges
    vecs[0] = '{32'h0000_00A5,   8, 1'b1, 32'h0,         32'h0000_00A5, 32'h0000_00A5,  8};
    vecs[1] = '{32'hDEAD_BEEF,   0, 1'b1, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 32};
    vecs[2] = '{32'h0000_0001,   1, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0001,  1};
    vecs[3] = '{32'h1234_5678,  40, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h1234_5678, 32};
    vecs[4] = '{32'h0000_01F3,   5, 1'b1, 32'h0,         32'h0000_0013, 32'h0000_0013,  5};
    vecs[5] = '{32'hFFFF_FFFF,  31, 1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 31};
    vecs[6] = '{32'h0000_0000,  32, 1'b0, 32'h8000_0001, 32'h8000_0001, 32'h0000_0000, 32};

    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_rx", rx_data, 32'd0);
    checkOutput("reset_clk_en", 32'(clock_en), 32'd0);
    checkOutput("reset_cs_n", 32'(cs_n), 32'd1);
    checkOutput("reset_mosi", 32'(mosi), 32'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].tx, vecs[i].len, vecs[i].loop,
                    vecs[i].pat, 1'b0, vecs[i].exp_rx, vecs[i].exp_mosi,
                    vecs[i].exp_edges, 0);
    end

`ifdef SPI_LSB_FIRST_EN
    applyStimulus("lsb_01", 32'h0000_0001, 8, 1'b1, 32'h0, 1'b1,
                  32'h0000_0001, 32'h0000_0001, 8, 0);
    applyStimulus("lsb_pat", 32'h0000_0035, 6, 1'b0, 32'h0000_002A, 1'b1,
                  32'h0000_002A, 32'h0000_0035, 6, 0);
`endif

    // Second start during the transfer must be dropped.
    applyStimulus("start_ignored", 32'h0000_003C, 8, 1'b1, 32'h0, 1'b0,
                  32'h0000_003C, 32'h0000_003C, 8, 1);

    // Stray strobes while idle must not touch any state.
    loop_mode = 1'b0;
    pat_word  = 32'hFFFF_FFFF;
    cur_len   = 32;
    rise_base = rise_total;
    begin
      int d0;
      d0 = done_total;
      gen_force = 1'b1;
      for (int i = 0; i < 8; i++) begin
        force_rise = (i % 2) == 0;
        force_fall = (i % 2) == 1;
        tick();
      end
      gen_force = 1'b0;
      tick();
      tick();
      checkOutput("stray_rx", rx_data, exp_prev_rx);
      checkOutput("stray_done", 32'(done_total - d0), 32'd0);
      checkOutput("stray_busy", 32'(busy), 32'd0);
      checkOutput("stray_mosi", 32'(mosi), 32'd0);
      checkOutput("stray_cs_n", 32'(cs_n), 32'd1);
    end

    // Reset in the middle of a transfer.
    applyStimulus("mid_reset", 32'h0000_00A5, 8, 1'b1, 32'h0, 1'b0,
                  32'h0000_00A5, 32'h0000_00A5, 8, 2);

    // Randomized transfers against the word-level model.
    for (int i = 0; i < 16; i++) begin
      rtx   = $urandom;
      rpat  = $urandom;
      rloop = 1'($urandom_range(0, 1));
      rlen  = $urandom_range(0, 63);
      rlsb  = 1'b0;
`ifdef SPI_LSB_FIRST_EN
      rlsb  = 1'($urandom_range(0, 1));
`endif
      l = modelLen(rlen);
      applyStimulus($sformatf("rand%0d", i), rtx, rlen, rloop, rpat, rlsb,
                    (rloop ? rtx : rpat) & modelMask(l), rtx & modelMask(l), l, 0);
    end

    checkOutput("gen_both_strobes", 32'(both_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- SPI transfer engine; sits directly downstream of the SPI clock generator.
- Gates that generator through clock_en_o and consumes its SCK edge strobes (rise_edge_i, fall_edge_i).
- Drives CS_n/MOSI, samples MISO, runs one full-duplex transfer of 1..DATA_W bits per start, mode 0 (CPOL=0, CPHA=0).
- Upstream APB register block supplies data/length/start and reads rx_data_o/busy_o/done_o.

Parameters:
DATA_W, 32, max transfer length and data width in bits
CNT_W, 6, width of length/bit counter; must satisfy 2**CNT_W > DATA_W

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  transfer request, sampled only in IDLE
tx_data_i  in  DATA_W  transmit word, right-aligned
tx_len_i  in  CNT_W  bits to transfer; 0 or >DATA_W means DATA_W
busy_o  out  1  high from cycle after accepted start until done_o cycle inclusive
done_o  out  1  one-cycle completion pulse
rx_data_o  out  DATA_W  received word, right-aligned, upper bits zero
clock_en_o  out  1  enable to SPI clock generator
rise_edge_i  in  1  strobe: SCK about to rise (from clock generator)
fall_edge_i  in  1  strobe: SCK about to fall (from clock generator)
spi_cs_n_o  out  1  chip select, active-low
spi_mosi_o  out  1  serial data out
spi_miso_i  in  1  serial data in

Behaviour:
- One clock (clk_i); reset synchronous, active-high (rst_i), all state registered.
- Reset values: busy_o=0, done_o=0, rx_data_o=0, clock_en_o=0, spi_cs_n_o=1, spi_mosi_o=0, FSM=IDLE, counters 0.
- FSM states IDLE, SETUP, XFER, HOLD, DONE.
- IDLE:
  - cs_n=1, clock_en=0.
  - start_i=1 latches tx_data_i and effective length L (tx_len_i clamped per Ports), clears rx shift reg and bit count, goes to SETUP.
- SETUP (exactly 1 cycle):
  - cs_n=0, mosi=tx[L-1], clock_en=0.
  - Next state XFER.
- XFER:
  - clock_en=1.
  - rise_edge_i: shift rx reg left, insert spi_miso_i at bit 0; bit count +1.
  - fall_edge_i with bit count<L: mosi takes next lower bit.
  - fall_edge_i with bit count==L: clock_en drops next cycle, go to HOLD.
  - Exactly L rising and L falling SCK edges per transfer; SCK ends low.
- HOLD (1 cycle): cs_n=0, clock_en=0; next DONE.
- DONE (1 cycle):
  - cs_n=1, done_o=1, rx_data_o loaded with rx reg (bits above L-1 zero).
  - mosi returns to 0, next IDLE.
- Latency from start_i to done_o: 3 + cycles until Lth fall edge.
- rx_data_o changes only in DONE and on reset; holds value otherwise.
- start_i outside IDLE is ignored (not queued).
- Edge strobes outside XFER are ignored.
- rise_edge_i and fall_edge_i high in the same cycle is illegal: process rise only; bench flags it as error.
- rst_i mid-transfer: next cycle all outputs at reset values, no done_o pulse, partial rx data discarded.
- Bit counter width CNT_W, never wraps: transfer ends at L.

Optional Feature:
- Macro SPI_LSB_FIRST_EN.
- Defined:
  - Adds input port lsb_first_i (1 bit), latched with start.
  - When 1, transmit tx[0] first, ascending to tx[L-1].
  - Received bits fill rx from bit 0 upward, first received bit at bit 0, so the result is right-aligned.
  - When 0, behaviour is identical to MSB-first.
- Not defined: port absent, MSB-first only.

Test Plan:
- Loopback MISO=MOSI, clock generator at div 4, tx=0xA5, len=8 -> MOSI sequence 1,0,1,0,0,1,0,1; 8 rise + 8 fall edges; rx_data_o=0x000000A5; done_o high exactly 1 cycle; cs_n low for whole transfer.
- len=0, tx=0xDEADBEEF, loopback -> 32 SCK cycles, rx_data_o=0xDEADBEEF.
- len=1, tx=0x1, MISO tied 0 -> one SCK pulse, MOSI=1, rx_data_o=0x0.
- start_i pulsed again at 3rd rise edge of an 8-bit transfer -> ignored; exactly one done_o, busy_o stays high until done_o.
- rst_i asserted after 3rd rise edge -> next cycle cs_n=1, clock_en_o=0, busy_o=0, rx_data_o=0, no done_o.
- SPI_LSB_FIRST_EN defined, lsb_first_i=1, tx=0x01, len=8, loopback -> first MOSI bit 1, then seven 0s; rx_data_o=0x01.
